// File: rtl/bid_agent_pkg.sv
// Shared bids22 types: the controller's bid error codes and the agent's state encoding.
package bids22defs;

   typedef enum logic [1:0] {
      NOBIDERROR        = 2'd0,
      INVALIDREQUEST    = 2'd1,
      INSUFFICIENTFUNDS = 2'd2
   } bid_err_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      WATCH  = 3'd2,
      BID    = 3'd3,
      HOLD   = 3'd4,
      DONE   = 3'd5,
      RESULT = 3'd6
   } agent_state_t;

endpackage

// File: rtl/bid_agent_if.sv
// One bidder port of the bids22 controller plus its broadcast round/max-bid signals.
interface bid_agent_if #(parameter int DATAWIDTH = 32);
   import bids22defs::*;

   logic                 bid;
   logic [DATAWIDTH-1:0] bidAmt;
   logic                 retract;
   logic                 ack;
   bid_err_t             err;
   logic                 win;
   logic [DATAWIDTH-1:0] balance;
   logic                 C_start;
   logic [DATAWIDTH-1:0] maxBid;
   logic [DATAWIDTH-1:0] bidCharge;

   modport master (
      output bid, bidAmt, retract,
      input  ack, err, win, balance, C_start, maxBid, bidCharge
   );

   modport slave (
      input  bid, bidAmt, retract,
      output ack, err, win, balance, C_start, maxBid, bidCharge
   );

endinterface

// File: rtl/bid_agent_calc.sv
// Combinational bid candidate (maxBid + step) and its feasibility against limit and funds.
module bid_agent_calc #(
   parameter int DATAWIDTH = 32
) (
   input  logic [DATAWIDTH-1:0] maxBid,
   input  logic [DATAWIDTH-1:0] step,
   input  logic [DATAWIDTH-1:0] limit,
   input  logic [DATAWIDTH-1:0] bidCharge,
   input  logic [DATAWIDTH-1:0] balance,
   output logic [DATAWIDTH-1:0] cand,
   output logic                 feasible
);

   logic [DATAWIDTH:0] cand_w;
   logic [DATAWIDTH:0] cost_w;

   // One extra bit keeps the carry visible; cand + charge cannot overflow it when cand has no carry.
   assign cand_w   = {1'b0, maxBid} + {1'b0, step};
   assign cost_w   = cand_w + {1'b0, bidCharge};
   assign cand     = cand_w[DATAWIDTH-1:0];
   assign feasible = !cand_w[DATAWIDTH]
                     && (cand_w <= {1'b0, limit})
                     && (cost_w < {1'b0, balance});

endmodule

// File: rtl/bid_agent.sv
// Autonomous bidder: outbids maxBid by a step up to a limit, then reports the round result.
// Define BID_AGENT_RETRACT_EN to let abort retract a leading bid; otherwise abort is ignored.
module bid_agent
   import bids22defs::*;
#(
   parameter int DATAWIDTH  = 32,
   parameter int HOLDOFF    = 2,
   parameter int MAXRETRY   = 3,
   parameter int RESULT_WIN = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_valid,
   input  logic [DATAWIDTH-1:0] cfg_limit,
   input  logic [DATAWIDTH-1:0] cfg_step,
   input  logic                 abort,
   bid_agent_if.master          bus,
   output logic [DATAWIDTH-1:0] lead_bid,
   output logic                 busy,
   output logic                 result_valid,
   output logic                 won
);

   localparam int RW  = $clog2(MAXRETRY + 1);
   localparam int HW  = $clog2(HOLDOFF + 1);
   localparam int RSW = $clog2(RESULT_WIN + 1);

   agent_state_t         state, state_nxt;
   logic [DATAWIDTH-1:0] limit_q, limit_nxt;
   logic [DATAWIDTH-1:0] step_q, step_nxt;
   logic [DATAWIDTH-1:0] amt_q, amt_nxt;
   logic [DATAWIDTH-1:0] lead_q, lead_nxt;
   logic [RW-1:0]        retry_q, retry_nxt, retry_inc;
   logic [HW-1:0]        hold_q, hold_nxt;
   logic [RSW-1:0]       res_q, res_nxt;
   logic                 won_q, won_nxt;
   logic                 rv_q, rv_nxt;
   logic                 retract_c;
   logic                 abort_en;
   logic                 rebid;
   logic [DATAWIDTH-1:0] cand;
   logic                 feasible;

`ifdef BID_AGENT_RETRACT_EN
   assign abort_en = abort;
`else
   logic unused_abort;
   assign abort_en     = 1'b0;
   assign unused_abort = abort;
`endif

   bid_agent_calc #(.DATAWIDTH(DATAWIDTH)) u_calc (
      .maxBid    (bus.maxBid),
      .step      (step_q),
      .limit     (limit_q),
      .bidCharge (bus.bidCharge),
      .balance   (bus.balance),
      .cand      (cand),
      .feasible  (feasible)
   );

   // A tie with our own lead is not a reason to re-bid.
   assign rebid     = (lead_q == '0) || (bus.maxBid > lead_q);
   assign retry_inc = retry_q + RW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         limit_q <= '0;
         step_q  <= '0;
         amt_q   <= '0;
         lead_q  <= '0;
         retry_q <= '0;
         hold_q  <= '0;
         res_q   <= '0;
         won_q   <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         limit_q <= limit_nxt;
         step_q  <= step_nxt;
         amt_q   <= amt_nxt;
         lead_q  <= lead_nxt;
         retry_q <= retry_nxt;
         hold_q  <= hold_nxt;
         res_q   <= res_nxt;
         won_q   <= won_nxt;
         rv_q    <= rv_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      limit_nxt = limit_q;
      step_nxt  = step_q;
      amt_nxt   = amt_q;
      lead_nxt  = lead_q;
      retry_nxt = retry_q;
      hold_nxt  = hold_q;
      res_nxt   = res_q;
      won_nxt   = won_q;
      rv_nxt    = 1'b0;
      retract_c = 1'b0;

      // Round end takes priority over everything else in the active states.
      if ((state == WATCH || state == BID || state == HOLD || state == DONE) && !bus.C_start) begin
         state_nxt = RESULT;
         res_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  limit_nxt = cfg_limit;
                  step_nxt  = cfg_step;
                  state_nxt = ARMED;
               end
            end
            ARMED: begin
               if (cfg_valid) begin
                  limit_nxt = cfg_limit;
                  step_nxt  = cfg_step;
               end
               if (bus.C_start) begin
                  lead_nxt  = '0;
                  won_nxt   = 1'b0;
                  retry_nxt = '0;
                  state_nxt = WATCH;
               end
            end
            WATCH: begin
               if (abort_en) begin
                  retract_c = (lead_q != '0);
                  lead_nxt  = '0;
                  state_nxt = DONE;
               end else if (rebid) begin
                  if (feasible) begin
                     amt_nxt   = cand;
                     state_nxt = BID;
                  end else begin
                     state_nxt = DONE;
                  end
               end
            end
            BID: begin
               hold_nxt = '0;
               if (bus.ack) begin
                  lead_nxt  = amt_q;
                  retry_nxt = '0;
                  state_nxt = HOLD;
               end else if (bus.err == INSUFFICIENTFUNDS) begin
                  state_nxt = DONE;
               end else if (bus.err == INVALIDREQUEST) begin
                  retry_nxt = retry_inc;
                  state_nxt = (retry_inc >= RW'(MAXRETRY)) ? DONE : HOLD;
               end else begin
                  state_nxt = HOLD;
               end
            end
            HOLD: begin
               if (abort_en) begin
                  retract_c = (lead_q != '0);
                  lead_nxt  = '0;
                  state_nxt = DONE;
               end else if (hold_q == HW'(HOLDOFF - 1)) begin
                  state_nxt = WATCH;
               end else begin
                  hold_nxt = hold_q + HW'(1);
               end
            end
            DONE: begin
               state_nxt = DONE;
            end
            RESULT: begin
               won_nxt = won_q | bus.win;
               if (res_q == RSW'(RESULT_WIN - 1)) begin
                  rv_nxt    = 1'b1;
                  state_nxt = ARMED;
               end else begin
                  res_nxt = res_q + RSW'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.bid      = (state == BID) && bus.C_start;
   assign bus.bidAmt   = amt_q;
   assign bus.retract  = retract_c;
   assign lead_bid     = lead_q;
   assign busy         = (state != IDLE) && (state != ARMED);
   assign result_valid = rv_q;
   assign won          = won_q;

endmodule

// File: tb/tb_bid_agent.sv
// Directed bench for bid_agent: bidding, limit/funds/overflow cut-offs, retries, result window, abort, reset.
module tb_bid_agent;
   import bids22defs::*;

   logic        clk;
   logic        reset;
   logic        cfg_valid;
   logic [31:0] cfg_limit;
   logic [31:0] cfg_step;
   logic        abort;
   logic [31:0] lead_bid;
   logic        busy;
   logic        result_valid;
   logic        won;

   int n_checks = 0;
   int n_errors = 0;

   bid_agent_if #(.DATAWIDTH(32)) bus ();

   bid_agent #(
      .DATAWIDTH(32), .HOLDOFF(2), .MAXRETRY(3), .RESULT_WIN(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_valid    (cfg_valid),
      .cfg_limit    (cfg_limit),
      .cfg_step     (cfg_step),
      .abort        (abort),
      .bus          (bus),
      .lead_bid     (lead_bid),
      .busy         (busy),
      .result_valid (result_valid),
      .won          (won)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input agent_state_t exp);
      check(tag, 64'(dut.state), 64'(exp));
   endtask

   // From the first HOLD cycle: two HOLD cycles, one WATCH, then BID.
   task automatic hold_to_bid(input string tag, input logic [31:0] amt);
      repeat (3) cyc();
      check({tag, "_bid"}, 64'(bus.bid), 64'(1));
      check({tag, "_amt"}, 64'(bus.bidAmt), 64'(amt));
   endtask

   task automatic end_round(input string tag, input int win_at, input logic exp_won);
      bus.C_start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         bus.win = (i == win_at);
         if (i == 1) chk_state({tag, "_in_result"}, RESULT);
         check({tag, "_rv_early"}, 64'(result_valid), 64'(0));
      end
      cyc();
      bus.win = 1'b0;
      check({tag, "_rv"}, 64'(result_valid), 64'(1));
      check({tag, "_won"}, 64'(won), 64'(exp_won));
      chk_state({tag, "_armed"}, ARMED);
      cyc();
      check({tag, "_rv_pulse"}, 64'(result_valid), 64'(0));
      check({tag, "_won_held"}, 64'(won), 64'(exp_won));
   endtask

   initial begin
      reset = 1'b1; cfg_valid = 1'b0; cfg_limit = '0; cfg_step = '0; abort = 1'b0;
      bus.ack = 1'b0; bus.err = NOBIDERROR; bus.win = 1'b0; bus.balance = '0;
      bus.C_start = 1'b0; bus.maxBid = '0; bus.bidCharge = '0;
      repeat (2) cyc();
      chk_state("rst_state", IDLE);
      check("rst_bid", 64'(bus.bid), 64'(0));
      check("rst_amt", 64'(bus.bidAmt), 64'(0));
      check("rst_lead", 64'(lead_bid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_rv_won", 64'({result_valid, won, bus.retract}), 64'(0));
      reset = 1'b0;
      cyc();

      // Basic bid: 0 + 5 = 5
      cfg_valid = 1'b1; cfg_limit = 100; cfg_step = 5;
      cyc();
      cfg_valid = 1'b0;
      chk_state("cfg_armed", ARMED);
      bus.balance = 1000; bus.bidCharge = 1; bus.maxBid = 0; bus.C_start = 1'b1;
      cyc();
      chk_state("start_watch", WATCH);
      check("watch_busy", 64'(busy), 64'(1));
      cyc();
      check("b1_bid", 64'(bus.bid), 64'(1));
      check("b1_amt", 64'(bus.bidAmt), 64'(5));
      bus.ack = 1'b1;
      cyc();
      bus.ack = 1'b0;
      check("b1_lead", 64'(lead_bid), 64'(5));
      check("b1_one_cycle", 64'(bus.bid), 64'(0));
      chk_state("b1_hold", HOLD);

      // Outbid 20 -> 25, spaced 4 cycles after the previous bid
      bus.maxBid = 20;
      repeat (2) cyc();
      check("b2_not_yet", 64'(bus.bid), 64'(0));
      cyc();
      check("b2_bid", 64'(bus.bid), 64'(1));
      check("b2_amt", 64'(bus.bidAmt), 64'(25));
      bus.ack = 1'b1;
      cyc();
      bus.ack = 1'b0;
      check("b2_lead", 64'(lead_bid), 64'(25));

      // Limit: 97 + 5 = 102 > 100
      bus.maxBid = 97;
      repeat (3) cyc();
      chk_state("limit_done", DONE);
      check("limit_nobid", 64'(bus.bid), 64'(0));
      check("limit_amt_held", 64'(bus.bidAmt), 64'(25));
      end_round("r1", 2, 1'b1);

      // Funds: 25 + 1 = 26 is not below a balance of 26
      bus.balance = 26; bus.maxBid = 20; bus.C_start = 1'b1;
      cyc();
      check("r2_won_clr", 64'(won), 64'(0));
      check("r2_lead_clr", 64'(lead_bid), 64'(0));
      cyc();
      chk_state("funds_done", DONE);
      check("funds_nobid", 64'(bus.bid), 64'(0));
      end_round("r2", 0, 1'b0);

      // Controller rejects for insufficient funds
      bus.balance = 1000; bus.maxBid = 0; bus.C_start = 1'b1;
      repeat (2) cyc();
      check("if_bid", 64'(bus.bid), 64'(1));
      bus.err = INSUFFICIENTFUNDS;
      cyc();
      bus.err = NOBIDERROR;
      chk_state("if_done", DONE);
      check("if_lead", 64'(lead_bid), 64'(0));
      end_round("r3", 0, 1'b0);

      // Retries: invalid, ack (clears count), then three invalids end the round
      bus.C_start = 1'b1;
      repeat (2) cyc();
      check("rt0_amt", 64'(bus.bidAmt), 64'(5));
      bus.err = INVALIDREQUEST;
      cyc();
      bus.err = NOBIDERROR;
      chk_state("rt0_hold", HOLD);
      hold_to_bid("rt1", 5);
      bus.ack = 1'b1;
      cyc();
      bus.ack = 1'b0;
      check("rt1_lead", 64'(lead_bid), 64'(5));
      bus.maxBid = 10;
      for (int k = 0; k < 3; k++) begin
         hold_to_bid("rt_retry", 15);
         bus.err = INVALIDREQUEST;
         cyc();
         bus.err = NOBIDERROR;
         chk_state("rt_after_invalid", (k == 2) ? DONE : HOLD);
      end
      end_round("r4", 0, 1'b0);

      // Overflow: 0xFFFFFFFE + 5 carries out
      cfg_valid = 1'b1; cfg_limit = 32'hFFFF_FFFF; cfg_step = 5;
      cyc();
      cfg_valid = 1'b0;
      chk_state("ovf_armed", ARMED);
      bus.balance = 32'hFFFF_FFFF; bus.maxBid = 32'hFFFF_FFFE; bus.C_start = 1'b1;
      repeat (2) cyc();
      chk_state("ovf_done", DONE);
      check("ovf_nobid", 64'(bus.bid), 64'(0));
      end_round("r5", 0, 1'b0);

      // Abort while leading with 5
      cfg_valid = 1'b1; cfg_limit = 100; cfg_step = 5;
      cyc();
      cfg_valid = 1'b0;
      bus.balance = 1000; bus.maxBid = 0; bus.C_start = 1'b1;
      repeat (2) cyc();
      bus.ack = 1'b1;
      cyc();
      bus.ack = 1'b0;
      check("ab_lead", 64'(lead_bid), 64'(5));
      abort = 1'b1;
      #1;
`ifdef BID_AGENT_RETRACT_EN
      check("ab_retract", 64'(bus.retract), 64'(1));
      check("ab_retract_nobid", 64'(bus.bid), 64'(0));
      cyc();
      abort = 1'b0;
      check("ab_retract_once", 64'(bus.retract), 64'(0));
      check("ab_lead_clr", 64'(lead_bid), 64'(0));
      chk_state("ab_done", DONE);
      end_round("r6", 0, 1'b0);
      bus.C_start = 1'b1;
      cyc();
`else
      check("ab_noretract", 64'(bus.retract), 64'(0));
      bus.maxBid = 20;
      hold_to_bid("ab_continue", 25);
      check("ab_noretract2", 64'(bus.retract), 64'(0));
      abort = 1'b0;
      bus.ack = 1'b1;
      cyc();
      bus.ack = 1'b0;
      // A tie with our own lead keeps the agent watching.
      bus.maxBid = 25;
      repeat (4) cyc();
      chk_state("tie_watch", WATCH);
      check("tie_nobid", 64'(bus.bid), 64'(0));
`endif

      // Asynchronous reset mid-round
      #2 reset = 1'b1;
      #1;
      chk_state("arst_state", IDLE);
      check("arst_amt", 64'(bus.bidAmt), 64'(0));
      check("arst_lead", 64'(lead_bid), 64'(0));
      check("arst_busy", 64'(busy), 64'(0));
      cyc();
      reset = 1'b0;
      repeat (2) cyc();
      chk_state("arst_needs_cfg", IDLE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
